// File: rtl/riscv_inter_core_types_pkg.sv
// Shared inter-core network types: message word layout, opcodes, queue sizing,
// plus the saturation value used by the inbox performance counters.
package riscv_inter_core_types_pkg;

  localparam int HART_ID_WIDTH       = 4;
  localparam int MAX_MSG_QUEUE_DEPTH = 16;
  localparam logic [31:0] IC_INBOX_PERF_SAT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IC_MSG_IDLE      = 3'd0,
    IC_MSG_INTERRUPT = 3'd1,
    IC_MSG_CACHE_INV = 3'd2,
    IC_MSG_DATA      = 3'd3,
    IC_MSG_SYNC      = 3'd4
  } inter_core_msg_opcode_e;

  typedef struct packed {
    logic                     valid;
    inter_core_msg_opcode_e   opcode;
    logic [HART_ID_WIDTH-1:0] src_hart;
    logic [HART_ID_WIDTH-1:0] dst_hart;
    logic [31:0]              data;
  } inter_core_msg_t;

endpackage

// File: rtl/riscv_ic_msg_fifo.sv
// Generic synchronous FIFO with combinational head read and extra-MSB pointers
// so full and empty are told apart without a separate flag.
module riscv_ic_msg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count;
  logic             do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign do_push = push_i && (count != PW'(DEPTH));
  assign do_pop  = pop_i && (count != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately unreset; only entries between the pointers are meaningful.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o    = count;

endmodule

// File: rtl/riscv_ic_msg_inbox.sv
// Per-hart inter-core receive endpoint: filters fabric words, latches IPIs, queues the rest.
// Optional performance counters are enabled by defining RISCV_IC_INBOX_PERF_EN.
import riscv_inter_core_types_pkg::*;

module riscv_ic_msg_inbox #(
  parameter logic [HART_ID_WIDTH-1:0] HART_ID = '0,
  parameter int                       DEPTH   = MAX_MSG_QUEUE_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  inter_core_msg_t            net_msg_i,
  output logic                       net_ready_o,
  output inter_core_msg_t            core_msg_o,
  output logic                       core_valid_o,
  input  logic                       core_ready_i,
  output logic                       ipi_pending_o,
  output logic [HART_ID_WIDTH-1:0]   ipi_src_o,
  input  logic                       ipi_clear_i,
  output logic                       misroute_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [31:0]                perf_rx_o,
  output logic [31:0]                perf_stall_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int MW = $bits(inter_core_msg_t);

  logic [CW-1:0]            count;
  logic [MW-1:0]            head_bits;
  inter_core_msg_t          head_msg;
  logic                     accept, for_me, is_idle, is_ipi;
  logic                     push, pop, ipi_hit;
  logic                     ipi_pending_q, ipi_pending_d;
  logic [HART_ID_WIDTH-1:0] ipi_src_q, ipi_src_d;
  logic                     misroute_q, misroute_d;

  // Ready depends only on flops and reset, never on the word or the core side.
  assign net_ready_o = !rst_i && (count < CW'(DEPTH));
  assign accept      = net_msg_i.valid && net_ready_o;
  assign is_idle     = (net_msg_i.opcode == IC_MSG_IDLE);
  assign is_ipi      = (net_msg_i.opcode == IC_MSG_INTERRUPT);
  assign for_me      = (net_msg_i.dst_hart == HART_ID);
  assign push        = accept && !is_idle && for_me && !is_ipi;
  assign ipi_hit     = accept && for_me && is_ipi;
  assign pop         = core_valid_o && core_ready_i;

  riscv_ic_msg_fifo #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (net_msg_i),
    .pop_i       (pop),
    .pop_data_o  (head_bits),
    .count_o     (count)
  );

  assign head_msg     = inter_core_msg_t'(head_bits);
  assign core_valid_o = (count != '0);
  assign count_o      = count;

  always_comb begin
    core_msg_o       = head_msg;
    core_msg_o.valid = 1'b1;
  end

  // A new IPI overrides a same-cycle clear; otherwise the first pending source is kept.
  always_comb begin
    ipi_pending_d = ipi_pending_q;
    ipi_src_d     = ipi_src_q;
    misroute_d    = accept && !is_idle && !for_me;
    if (ipi_clear_i) begin
      ipi_pending_d = 1'b0;
    end
    if (ipi_hit) begin
      ipi_pending_d = 1'b1;
      if (!ipi_pending_q || ipi_clear_i) begin
        ipi_src_d = net_msg_i.src_hart;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ipi_pending_q <= 1'b0;
      ipi_src_q     <= '0;
      misroute_q    <= 1'b0;
    end else begin
      ipi_pending_q <= ipi_pending_d;
      ipi_src_q     <= ipi_src_d;
      misroute_q    <= misroute_d;
    end
  end

  assign ipi_pending_o = ipi_pending_q;
  assign ipi_src_o     = ipi_src_q;
  assign misroute_o    = misroute_q;

`ifdef RISCV_IC_INBOX_PERF_EN
  logic [31:0] perf_rx_q, perf_rx_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        rx_inc, stall_inc;

  assign rx_inc    = accept && for_me && !is_idle;
  assign stall_inc = net_msg_i.valid && !net_ready_o;

  always_comb begin
    perf_rx_d    = perf_rx_q;
    perf_stall_d = perf_stall_q;
    if (rx_inc && (perf_rx_q != IC_INBOX_PERF_SAT)) begin
      perf_rx_d = perf_rx_q + 32'd1;
    end
    if (stall_inc && (perf_stall_q != IC_INBOX_PERF_SAT)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_rx_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_rx_q    <= perf_rx_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_rx_o    = perf_rx_q;
  assign perf_stall_o = perf_stall_q;
`else
  assign perf_rx_o    = 32'h0;
  assign perf_stall_o = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_ic_msg_inbox.sv
// Scoreboard bench for riscv_ic_msg_inbox: the driver queues expected FIFO words,
// an independent monitor pops and compares them whenever the core handshake fires.
import riscv_inter_core_types_pkg::*;

module tb_riscv_ic_msg_inbox;

  localparam int DEPTH = 16;
  localparam logic [HART_ID_WIDTH-1:0] MY_HART = 4'd0;

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b1;
  inter_core_msg_t          net_msg_i = '0;
  logic                     net_ready_o;
  inter_core_msg_t          core_msg_o;
  logic                     core_valid_o;
  logic                     core_ready_i = 1'b0;
  logic                     ipi_pending_o;
  logic [HART_ID_WIDTH-1:0] ipi_src_o;
  logic                     ipi_clear_i = 1'b0;
  logic                     misroute_o;
  logic [$clog2(DEPTH):0]   count_o;
  logic [31:0]              perf_rx_o;
  logic [31:0]              perf_stall_o;

  int checks = 0;
  int errors = 0;
  int exp_rx = 0;
  inter_core_msg_t exp_q [$];

  riscv_ic_msg_inbox #(
    .HART_ID (MY_HART),
    .DEPTH   (DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .net_msg_i     (net_msg_i),
    .net_ready_o   (net_ready_o),
    .core_msg_o    (core_msg_o),
    .core_valid_o  (core_valid_o),
    .core_ready_i  (core_ready_i),
    .ipi_pending_o (ipi_pending_o),
    .ipi_src_o     (ipi_src_o),
    .ipi_clear_i   (ipi_clear_i),
    .misroute_o    (misroute_o),
    .count_o       (count_o),
    .perf_rx_o     (perf_rx_o),
    .perf_stall_o  (perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (errors so far %0d)", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic inter_core_msg_t mk(input inter_core_msg_opcode_e op,
                                         input logic [3:0] src, input logic [3:0] dst,
                                         input logic [31:0] data);
    inter_core_msg_t m;
    m.valid    = 1'b1;
    m.opcode   = op;
    m.src_hart = src;
    m.dst_hart = dst;
    m.data     = data;
    return m;
  endfunction

  // Present one word and hold it until accepted; model what the inbox should do with it.
  task automatic send(input inter_core_msg_t m);
    int  waited;
    bit  got;
    waited = 0;
    got    = 1'b0;
    @(posedge clk_i); #1;
    net_msg_i = m;
    while (!got && waited < 64) begin
      @(negedge clk_i);
      if (net_ready_o) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      chk("send_accept_timeout", 32'd0, 32'd1);
    end else begin
      if (m.dst_hart == MY_HART && m.opcode != IC_MSG_IDLE) exp_rx++;
      if (m.dst_hart == MY_HART && m.opcode != IC_MSG_IDLE && m.opcode != IC_MSG_INTERRUPT)
        exp_q.push_back(m);
    end
    @(posedge clk_i); #1;
    net_msg_i = '0;
    $display("SEND op=%0d src=%0d dst=%0d data=0x%0h accepted=%0d",
             m.opcode, m.src_hart, m.dst_hart, m.data, got);
  endtask

  // Monitor: every core-side handshake must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i && core_valid_o && core_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got data 0x%0h, expected no message", core_msg_o.data);
      end else begin
        inter_core_msg_t e;
        e = exp_q.pop_front();
        if (core_msg_o !== e) begin
          errors++;
          $display("FAIL pop_data: got op=%0d src=%0d data=0x%0h, expected op=%0d src=%0d data=0x%0h",
                   core_msg_o.opcode, core_msg_o.src_hart, core_msg_o.data,
                   e.opcode, e.src_hart, e.data);
        end else begin
          $display("POP data=0x%0h op=%0d", core_msg_o.data, core_msg_o.opcode);
        end
      end
    end
  end

  task automatic drain();
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    core_ready_i = 1'b1;
    while (!done && n < 40) begin
      @(negedge clk_i);
      if (count_o == '0) done = 1'b1;
      n++;
    end
    core_ready_i = 1'b0;
    chk("drain_done", {31'd0, done}, 32'd1);
    chk("drain_valid_low", {31'd0, core_valid_o}, 32'd0);
    chk("drain_scoreboard_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    inter_core_msg_t m17;

    // 1. Reset
    repeat (3) begin
      @(negedge clk_i);
      chk("ready_in_reset", {31'd0, net_ready_o}, 32'd0);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready", {31'd0, net_ready_o}, 32'd1);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_valid", {31'd0, core_valid_o}, 32'd0);
    chk("rst_ipi_pending", {31'd0, ipi_pending_o}, 32'd0);
    chk("rst_ipi_src", 32'(ipi_src_o), 32'd0);
    chk("rst_misroute", {31'd0, misroute_o}, 32'd0);
    chk("rst_perf_rx", perf_rx_o, 32'd0);
    chk("rst_perf_stall", perf_stall_o, 32'd0);

    // 2. Three words in order
    send(mk(IC_MSG_CACHE_INV, 4'd1, MY_HART, 32'h11));
    send(mk(IC_MSG_CACHE_INV, 4'd1, MY_HART, 32'h22));
    send(mk(IC_MSG_CACHE_INV, 4'd1, MY_HART, 32'h33));
    @(negedge clk_i);
    chk("t2_count3", 32'(count_o), 32'd3);
    @(posedge clk_i); #1;
    core_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    @(negedge clk_i);
    chk("t2_valid_low_after_3", {31'd0, core_valid_o}, 32'd0);
    chk("t2_count0", 32'(count_o), 32'd0);
    core_ready_i = 1'b0;

    // 3. Fill to DEPTH, hold the 17th, pop one to let it in
    for (int i = 0; i < DEPTH; i++)
      send(mk(IC_MSG_DATA, 4'd2, MY_HART, 32'h100 + 32'(i)));
    @(negedge clk_i);
    chk("t3_count_full", 32'(count_o), 32'd16);
    chk("t3_ready_full", {31'd0, net_ready_o}, 32'd0);
    m17 = mk(IC_MSG_DATA, 4'd3, MY_HART, 32'h200);
    @(posedge clk_i); #1;
    net_msg_i = m17;
    repeat (2) begin
      @(negedge clk_i);
      chk("t3_held_ready", {31'd0, net_ready_o}, 32'd0);
      chk("t3_held_count", 32'(count_o), 32'd16);
    end
    @(posedge clk_i); #1;
    core_ready_i = 1'b1;
    @(posedge clk_i); #1;
    core_ready_i = 1'b0;
    @(negedge clk_i);
    chk("t3_ready_after_pop", {31'd0, net_ready_o}, 32'd1);
    exp_q.push_back(m17);
    exp_rx++;
    @(posedge clk_i); #1;
    net_msg_i = '0;
    $display("SEND op=%0d src=3 dst=0 data=0x200 accepted=1 (held word)", m17.opcode);
    @(negedge clk_i);
    chk("t3_count_refill", 32'(count_o), 32'd16);
    drain();

    // 4. Misroute and idle
    send(mk(IC_MSG_DATA, 4'd1, MY_HART + 4'd1, 32'hBAD));
    @(negedge clk_i);
    chk("t4_misroute_pulse", {31'd0, misroute_o}, 32'd1);
    chk("t4_count_misroute", 32'(count_o), 32'd0);
    @(negedge clk_i);
    chk("t4_misroute_one_cycle", {31'd0, misroute_o}, 32'd0);
    send(mk(IC_MSG_IDLE, 4'd1, MY_HART, 32'h0));
    @(negedge clk_i);
    chk("t4_idle_no_misroute", {31'd0, misroute_o}, 32'd0);
    chk("t4_idle_count", 32'(count_o), 32'd0);

    // 5. IPIs
    send(mk(IC_MSG_INTERRUPT, 4'd2, MY_HART, 32'h0));
    send(mk(IC_MSG_INTERRUPT, 4'd3, MY_HART, 32'h0));
    @(negedge clk_i);
    chk("t5_pending", {31'd0, ipi_pending_o}, 32'd1);
    chk("t5_first_src_wins", 32'(ipi_src_o), 32'd2);
    chk("t5_ipi_not_queued", 32'(count_o), 32'd0);
    @(posedge clk_i); #1;
    net_msg_i   = mk(IC_MSG_INTERRUPT, 4'd1, MY_HART, 32'h0);
    ipi_clear_i = 1'b1;
    @(negedge clk_i);
    chk("t5_ready_ipi_clear", {31'd0, net_ready_o}, 32'd1);
    exp_rx++;
    @(posedge clk_i); #1;
    net_msg_i   = '0;
    ipi_clear_i = 1'b0;
    $display("SEND op=1 src=1 dst=0 with ipi_clear accepted=1");
    @(negedge clk_i);
    chk("t5_pending_new_wins", {31'd0, ipi_pending_o}, 32'd1);
    chk("t5_src_new_wins", 32'(ipi_src_o), 32'd1);
    @(posedge clk_i); #1;
    ipi_clear_i = 1'b1;
    @(posedge clk_i); #1;
    ipi_clear_i = 1'b0;
    @(negedge clk_i);
    chk("t5_cleared", {31'd0, ipi_pending_o}, 32'd0);
`ifdef RISCV_IC_INBOX_PERF_EN
    chk("t5_perf_rx_total", perf_rx_o, 32'(exp_rx));
`else
    chk("t5_perf_rx_total", perf_rx_o, 32'd0);
`endif

    // 6. Fresh reset, 1 IPI + 16 words, 4 stall cycles, then reset mid-operation
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    send(mk(IC_MSG_INTERRUPT, 4'd5, MY_HART, 32'h0));
    for (int i = 0; i < DEPTH; i++)
      send(mk(IC_MSG_SYNC, 4'd6, MY_HART, 32'h300 + 32'(i)));
    @(posedge clk_i); #1;
    net_msg_i = mk(IC_MSG_DATA, 4'd6, MY_HART, 32'h3FF);
    repeat (4) @(posedge clk_i);
    #1;
    net_msg_i = '0;
    @(negedge clk_i);
    chk("t6_ipi_src", 32'(ipi_src_o), 32'd5);
`ifdef RISCV_IC_INBOX_PERF_EN
    chk("t6_perf_rx", perf_rx_o, 32'd17);
    chk("t6_perf_stall", perf_stall_o, 32'd4);
`else
    chk("t6_perf_rx", perf_rx_o, 32'd0);
    chk("t6_perf_stall", perf_stall_o, 32'd0);
`endif
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    exp_q.delete();
    @(negedge clk_i);
    chk("t6_ready_in_reset", {31'd0, net_ready_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("t6_rst_count", 32'(count_o), 32'd0);
    chk("t6_rst_valid", {31'd0, core_valid_o}, 32'd0);
    chk("t6_rst_pending", {31'd0, ipi_pending_o}, 32'd0);
    chk("t6_rst_src", 32'(ipi_src_o), 32'd0);
    chk("t6_rst_perf_rx", perf_rx_o, 32'd0);
    chk("t6_rst_perf_stall", perf_stall_o, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
